// File: rtl/pipe_pkg.sv
// Shared opcode, field and decode types for the five-stage pipeline.
// Imported by the hazard unit and its per-stage operand decoders.
package pipe_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    localparam logic [31:0] NOP_WORD = 32'h6800_0000;
    localparam logic [3:0]  RA       = 4'd15;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 27;
    localparam int IMM_BIT = 26;
    localparam int RD_HI   = 25;
    localparam int RD_LO   = 22;
    localparam int RS1_HI  = 21;
    localparam int RS1_LO  = 18;
    localparam int RS2_HI  = 17;
    localparam int RS2_LO  = 14;

    typedef enum logic {
        RUN,
        MC_HOLD
    } hcu_state_e;

    typedef struct packed {
        logic       s1_v;
        logic [3:0] s1;
        logic       s2_v;
        logic [3:0] s2;
        logic       d_v;
        logic [3:0] d;
    } regs_t;

    function automatic logic is_branch(input logic [4:0] op);
        return (op >= OP_BEQ) && (op <= OP_RET);
    endfunction

    function automatic logic is_mc(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

    function automatic logic is_ld(input logic [4:0] op);
        return op == OP_LD;
    endfunction

endpackage

// File: rtl/hazard_control_unit_operand_decoder.sv
// Extracts source/destination register ids and their existence bits
// from one instruction word; one copy sits on each pipeline stage.
module operand_decoder
    import pipe_pkg::*;
(
    input  logic [31:0] instr_i,
    output regs_t       regs_o
);

    logic [4:0] opc;
    logic       imm;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       alu;
    logic       unused_low;

    assign opc = instr_i[OPC_HI:OPC_LO];
    assign imm = instr_i[IMM_BIT];
    assign rd  = instr_i[RD_HI:RD_LO];
    assign rs1 = instr_i[RS1_HI:RS1_LO];
    assign rs2 = instr_i[RS2_HI:RS2_LO];
    assign alu = (opc <= OP_ASR);

    assign unused_low = ^instr_i[13:0];

    always_comb begin
        regs_o = '0;

        unique case (1'b1)
            (alu && opc != OP_NOT && opc != OP_MOV),
            (opc == OP_LD),
            (opc == OP_ST): begin
                regs_o.s1_v = 1'b1;
                regs_o.s1   = rs1;
            end
            (opc == OP_RET): begin
                regs_o.s1_v = 1'b1;
                regs_o.s1   = RA;
            end
            default: ;
        endcase

        // A store reads its data register through the rd field.
        unique case (1'b1)
            (opc == OP_ST): begin
                regs_o.s2_v = 1'b1;
                regs_o.s2   = rd;
            end
            (alu && !imm): begin
                regs_o.s2_v = 1'b1;
                regs_o.s2   = rs2;
            end
            default: ;
        endcase

        unique case (1'b1)
            (opc == OP_CALL): begin
                regs_o.d_v = 1'b1;
                regs_o.d   = RA;
            end
            (alu && opc != OP_CMP),
            (opc == OP_LD): begin
                regs_o.d_v = 1'b1;
                regs_o.d   = rd;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline IR registers with forwarding select, load-use stall,
// taken-branch flush and multicycle EX occupancy control.
module hazard_control_unit
    import pipe_pkg::*;
#(
    parameter int MC_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_instr,
    input  logic        branch_taken,
    output logic [31:0] of_ir,
    output logic [31:0] ex_ir,
    output logic [31:0] ma_ir,
    output logic [31:0] rw_ir,
    output logic        pc_stall,
    output logic        flush,
    output logic [1:0]  fwd_op1_sel,
    output logic [1:0]  fwd_op2_sel,
    output logic        mc_busy
);

    localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MC_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    hcu_state_e  state_q;
    logic [CW-1:0] cnt_q;

    logic [31:0] of_q, ex_q, ma_q, rw_q;
    logic [31:0] of_d, ex_d, ma_d, rw_d;

    regs_t of_r, ex_r, ma_r, rw_r;

    logic [4:0] ex_op;
    logic       take;
    logic       mc_hold;
    logic       lu_hit;
    logic       lu_stall;
    logic       unused_fields;

    operand_decoder u_dec_of (.instr_i(of_q), .regs_o(of_r));
    operand_decoder u_dec_ex (.instr_i(ex_q), .regs_o(ex_r));
    operand_decoder u_dec_ma (.instr_i(ma_q), .regs_o(ma_r));
    operand_decoder u_dec_rw (.instr_i(rw_q), .regs_o(rw_r));

    assign unused_fields = ^{of_r.d_v, of_r.d,
                             ma_r.s1_v, ma_r.s1, ma_r.s2_v, ma_r.s2,
                             rw_r.s1_v, rw_r.s1, rw_r.s2_v, rw_r.s2};

    function automatic logic [1:0] fwd_sel(
        input logic       v,
        input logic [3:0] r,
        input regs_t      ma,
        input regs_t      rw
    );
        if (v && ma.d_v && ma.d == r)
            return 2'b01;
        if (v && rw.d_v && rw.d == r)
            return 2'b10;
        return 2'b00;
    endfunction

    assign ex_op = ex_q[OPC_HI:OPC_LO];

    always_comb begin
        take    = is_branch(ex_op) && branch_taken;
        // In MC_HOLD the final count is the release cycle, not a hold.
        mc_hold = (MC_CYCLES > 1) && is_mc(ex_op) &&
                  (state_q == RUN || cnt_q != LAST);
        lu_hit  = is_ld(ex_op) && ex_r.d_v &&
                  ((of_r.s1_v && of_r.s1 == ex_r.d) ||
                   (of_r.s2_v && of_r.s2 == ex_r.d));

        flush    = take;
        mc_busy  = !take && mc_hold;
        lu_stall = !take && !mc_hold && lu_hit;
        pc_stall = mc_busy || lu_stall;

        fwd_op1_sel = fwd_sel(ex_r.s1_v, ex_r.s1, ma_r, rw_r);
        fwd_op2_sel = fwd_sel(ex_r.s2_v, ex_r.s2, ma_r, rw_r);
    end

    always_comb begin
        of_d = if_instr;
        ex_d = of_q;
        ma_d = ex_q;
        rw_d = ma_q;
        unique case (1'b1)
            flush: begin
                of_d = NOP_WORD;
                ex_d = NOP_WORD;
            end
            mc_busy: begin
                of_d = of_q;
                ex_d = ex_q;
                ma_d = NOP_WORD;
            end
            lu_stall: begin
                of_d = of_q;
                ex_d = NOP_WORD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            of_q <= NOP_WORD;
            ex_q <= NOP_WORD;
            ma_q <= NOP_WORD;
            rw_q <= NOP_WORD;
        end else begin
            of_q <= of_d;
            ex_q <= ex_d;
            ma_q <= ma_d;
            rw_q <= rw_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mc_busy) begin
                        state_q <= MC_HOLD;
                        cnt_q   <= ONE;
                    end
                end
                MC_HOLD: begin
                    if (mc_busy) begin
                        cnt_q <= cnt_q + ONE;
                    end else begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign of_ir = of_q;
    assign ex_ir = ex_q;
    assign ma_ir = ma_q;
    assign rw_ir = rw_q;

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 MC_CYCLES, default 4; number of EX cycles occupied by mul/div/mod (legal 1..16).
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_instr  input  32  instruction fetched this cycle.
REQ-005 branch_taken  input  1  EX branch resolution; meaningful only when ex_ir is b/beq/bgt/call/ret.
REQ-006 of_ir, ex_ir, ma_ir, rw_ir  output  32 each  instruction currently held in OF/EX/MA/RW.
REQ-007 pc_stall  output  1  hold PC and IF this cycle.
REQ-008 flush  output  1  taken-branch squash pulse.
REQ-009 fwd_op1_sel, fwd_op2_sel  output  2 each  EX operand source: 00 regfile/OF, 01 MA result, 10 RW result.
REQ-010 mc_busy  output  1  multicycle op holding EX.

Function
REQ-011 Fields: opcode [31:27], I [26], rd [25:22], rs1 [21:18], rs2 [17:14].
REQ-012 src1 exists for add/sub/mul/div/mod/cmp/and/or/lsl/lsr/asr/ld/st (rs1); ret reads src1 = 4'd15; none otherwise.
REQ-013 src2 = rd field for st (regardless of I); = rs2 for ALU/cmp/not/mov only when I=0; none otherwise.
REQ-014 dest = 4'd15 for call; = rd for ALU ops except cmp, plus ld/not/mov; none for nop/cmp/st/b/beq/bgt/ret.
REQ-015 Match = both fields exist and 4-bit values equal; no register is exempt.
REQ-016 fwd_opN_sel combinational: 01 if ma_ir dest matches ex_ir srcN, else 10 if rw_ir dest matches, else 00; MA wins.
REQ-017 Normal edge: rw_ir<=ma_ir, ma_ir<=ex_ir, ex_ir<=of_ir, of_ir<=if_instr.
REQ-018 Load-use: ex_ir is ld and its dest matches of_ir src1 or src2 -> pc_stall=1 that cycle; of_ir holds, ex_ir<=NOP, MA/RW advance; exactly one bubble.
REQ-019 Branch: ex_ir branch-type and branch_taken=1 -> flush=1 that cycle; of_ir<=NOP, ex_ir<=NOP, MA/RW advance; pc_stall=0.
REQ-020 FSM states RUN, MC_HOLD; counter width clog2(MC_CYCLES).
REQ-021 Multicycle: from first cycle mul/div/mod is in ex_ir, pc_stall=mc_busy=1 for exactly MC_CYCLES-1 consecutive cycles; of_ir/ex_ir hold, ma_ir<=NOP, rw_ir advances; op moves to MA on edge MC_CYCLES.
REQ-022 MC_CYCLES=1 -> no hold, FSM stays RUN.
REQ-023 Back-to-back multicycle ops each receive full occupancy; no shared cycle.
REQ-024 Priority: branch > multicycle > load-use > normal (conditions on ex_ir are mutually exclusive by opcode; priority fixed regardless).
REQ-025 pc_stall, flush, mc_busy decoded from registered state and current inputs; no combinational path from if_instr to pc_stall.

Reset
REQ-026 rst_n low -> all IR registers = NOP word 32'h6800_0000, FSM=RUN, counter=0 immediately.
REQ-027 During and after reset: pc_stall=0, flush=0, mc_busy=0, fwd sels=00.
REQ-028 Reset mid-MC_HOLD aborts the hold; first post-reset edge behaves as normal.

Structure
REQ-029 Package pipe_pkg: 5-bit opcode constants (add=0 .. ret=20), NOP_WORD, RA=4'd15, field bit positions.
REQ-030 One sub-module operand_decoder: instruction -> src1/src2/dest with exist bits; instantiated per stage (OF, EX, MA, RW).

Verification
REQ-031 add r1,r2,r3; sub r4,r1,r5 back-to-back -> sub in EX: fwd_op1_sel=01; with one nop between: 10.
REQ-032 ld r1,[r2]; add r5,r6,r1 -> pc_stall=1 one cycle, ex_ir=NOP next; add reaches EX with fwd_op2_sel=10.
REQ-033 beq in EX, branch_taken=1 -> flush=1 one cycle; next cycle of_ir=ex_ir=32'h6800_0000; ma_ir=beq.
REQ-034 div r1,r2,r3 with MC_CYCLES=4 -> mc_busy/pc_stall high 3 cycles, ma_ir=NOP during hold, div in MA after edge 4.
REQ-035 call then ret -> ret in EX: fwd_op1_sel=01; add r3,r1,r2; st r3,[r4] (I=1) -> fwd_op2_sel=01.
REQ-036 rst_n low in 2nd hold cycle -> mc_busy=0 and all IRs NOP without a clock edge.
